// File: rtl/pipe_delay_line_pkg.sv
// Shared types and helpers for the multi-lane tapped delay line.
package delay_pkg;

    // Per-edge action, highest priority first: flush, retune, shift, hold.
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_SHIFT,
        ACT_RETUNE,
        ACT_FLUSH
    } act_e;

    function automatic int clamp_tap(input int tap, input int depth);
        if (tap < 1) return 1;
        if (tap > depth) return depth;
        return tap;
    endfunction

endpackage

// File: rtl/pipe_delay_line_stage.sv
// One delay stage: loads data/valid on enable, with an overriding valid clear.
module delay_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr_valid,
    input  logic         d_valid,
    input  logic [W-1:0] d_data,
    output logic         q_valid,
    output logic [W-1:0] q_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else begin
            if (load) q_data <= d_data;
            if (clr_valid)   q_valid <= 1'b0;
            else if (load)   q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/pipe_delay_line.sv
// N-stage multi-lane delay line with a runtime tap, clock enable and flush.
module pipe_delay_line
    import delay_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    parameter  int CH    = 2,
    localparam int TAPW  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    input  logic [TAPW-1:0]    tap,
    input  logic               in_valid,
    input  logic [CH*WIDTH-1:0] in_data,
    output logic               out_valid,
    output logic [CH*WIDTH-1:0] out_data,
    output logic [TAPW-1:0]    cur_tap
);

    localparam int DW = CH * WIDTH;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] data;
    } stage_t;

    logic [TAPW-1:0]         tap_q;
    logic [TAPW-1:0]         tap_new;
    logic                    tap_chg;
    act_e                    act;
    logic [DEPTH:1]          v_q;
    logic [DEPTH:1][DW-1:0]  d_q;
    stage_t                  sel;

    assign tap_new = TAPW'(clamp_tap(int'(tap), DEPTH));
    assign tap_chg = (tap_new != tap_q);

    always_comb begin
        act = ACT_HOLD;
        if (flush)        act = ACT_FLUSH;
        else if (tap_chg) act = ACT_RETUNE;
        else if (en)      act = ACT_SHIFT;
    end

    // A retune is honoured regardless of en so the output never reads a stale tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tap_q <= TAPW'(DEPTH);
        else if (tap_chg) tap_q <= tap_new;
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        logic          d_valid;
        logic [DW-1:0] d_data;
        logic          clr;

        if (k == 1) begin : g_first
            assign d_valid = in_valid;
            assign d_data  = in_data;
        end else begin : g_next
            assign d_valid = v_q[k-1];
            assign d_data  = d_q[k-1];
        end

        // Retune keeps only a freshly captured r[1] so no sample is skipped or repeated.
        assign clr = (act == ACT_FLUSH) ||
                     ((act == ACT_RETUNE) && ((k > 1) || !en));

        delay_stage #(.W(DW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (en),
            .clr_valid (clr),
            .d_valid   (d_valid),
            .d_data    (d_data),
            .q_valid   (v_q[k]),
            .q_data    (d_q[k])
        );
    end

    always_comb begin
        sel = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (tap_q == TAPW'(k)) sel = '{valid: v_q[k], data: d_q[k]};
        end
    end

    assign out_valid = sel.valid;
    assign out_data  = sel.data;
    assign cur_tap   = tap_q;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Scoreboard bench for pipe_delay_line: streaming, stall, retune, flush, clamp, reset.
module tb_pipe_delay_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CH    = 2;
    localparam int TAPW  = $clog2(DEPTH + 1);
    localparam int DW    = CH * WIDTH;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            flush;
    logic [TAPW-1:0] tap;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [TAPW-1:0] cur_tap;

    logic [DW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    pipe_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .tap       (tap),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cur_tap   (cur_tap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; flush = 1'b0; tap = 3'd4;
        in_valid = 1'b0; in_data = '0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=0000", out_data); end
        total++; if (cur_tap !== 3'd4) begin bad++; $display("FAIL reset_tap got=%0d want=4", cur_tap); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [DW-1:0] e;
        logic          want;
        tap = 3'd4; en = 1'b1; flush = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            in_valid = (j <= 8);
            in_data  = {2{8'(j)}};
            if (j <= 8) exp_q.push_back(in_data);
            tick();
            want = (j >= 4) && (j <= 11);
            total++;
            if (out_valid !== want) begin
                bad++; $display("FAIL stream_valid edge=%0d got=%b want=%b", j, out_valid, want);
            end else if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (out_data !== e) begin bad++; $display("FAIL stream_data edge=%0d got=%h want=%h", j, out_data, e); end
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] e;
        logic          want;
        tap = 3'd2; en = 1'b1; flush = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            in_valid = 1'b1;
            in_data  = {2{8'(8'h10 + j)}};
            exp_q.push_back(in_data);
            tick();
            want = (j >= 2);
            total++;
            if (out_valid !== want) begin
                bad++; $display("FAIL stall_fill_valid edge=%0d got=%b want=%b", j, out_valid, want);
            end else if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (out_data !== e) begin bad++; $display("FAIL stall_fill_data edge=%0d got=%h want=%h", j, out_data, e); end
            end
        end
        en = 1'b0; in_valid = 1'b1; in_data = 16'hEEEE;
        for (int j = 1; j <= 3; j++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'h1313) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/1313", j, out_valid, out_data);
            end
        end
        en = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            in_valid = (j == 1);
            in_data  = 16'h1515;
            if (j == 1) exp_q.push_back(in_data);
            tick();
            want = (j <= 2);
            total++;
            if (out_valid !== want) begin
                bad++; $display("FAIL stall_resume_valid edge=%0d got=%b want=%b", j, out_valid, want);
            end else if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (out_data !== e) begin bad++; $display("FAIL stall_resume_data edge=%0d got=%h want=%h", j, out_data, e); end
            end
        end
    endtask

    task automatic test_retune();
        logic [DW-1:0] e;
        tap = 3'd4; en = 1'b1; flush = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            in_valid = 1'b1;
            in_data  = {2{8'(8'h30 + j)}};
            exp_q.push_back(in_data);
            tick();
            total++;
            if (out_valid !== (j == 4)) begin
                bad++; $display("FAIL retune_fill_valid edge=%0d got=%b want=%b", j, out_valid, (j == 4));
            end else if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (out_data !== e) begin bad++; $display("FAIL retune_fill_data edge=%0d got=%h want=%h", j, out_data, e); end
            end
        end
        // Samples still in flight are dropped by the retune.
        exp_q.delete();
        tap = 3'd2; in_valid = 1'b1; in_data = 16'h0909;
        exp_q.push_back(in_data);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL retune_gap got=%b want=0", out_valid); end
        total++; if (cur_tap !== 3'd2) begin bad++; $display("FAIL retune_tap got=%0d want=2", cur_tap); end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL retune_arrive_valid got=%b want=1", out_valid);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (out_data !== e) begin bad++; $display("FAIL retune_arrive_data got=%h want=%h", out_data, e); end
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL retune_after got=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] e;
        tap = 3'd2; en = 1'b1; flush = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            in_valid = 1'b1;
            in_data  = {2{8'(8'h40 + j)}};
            exp_q.push_back(in_data);
            tick();
            total++;
            if (out_valid !== (j == 2)) begin
                bad++; $display("FAIL flush_fill_valid edge=%0d got=%b want=%b", j, out_valid, (j == 2));
            end else if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (out_data !== e) begin bad++; $display("FAIL flush_fill_data edge=%0d got=%h want=%h", j, out_data, e); end
            end
        end
        exp_q.delete();
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h0505;
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b want=0", out_valid); end
        in_data = 16'h0606;
        exp_q.push_back(in_data);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_0505 got=%b/%h want=0", out_valid, out_data); end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL flush_next_valid got=%b want=1", out_valid);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (out_data !== e) begin bad++; $display("FAIL flush_next_data got=%h want=%h", out_data, e); end
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_after got=%b want=0", out_valid); end
    endtask

    task automatic test_clamp();
        en = 1'b0; in_valid = 1'b0; flush = 1'b0;
        tap = 3'd0;
        tick();
        total++; if (cur_tap !== 3'd1) begin bad++; $display("FAIL clamp_zero got=%0d want=1", cur_tap); end
        tap = 3'd7;
        tick();
        total++; if (cur_tap !== 3'd4) begin bad++; $display("FAIL clamp_high got=%0d want=4", cur_tap); end
        tap = 3'd3;
        tick();
        total++; if (cur_tap !== 3'd3) begin bad++; $display("FAIL clamp_mid got=%0d want=3", cur_tap); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clamp_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] e;
        tap = 3'd2; en = 1'b1; flush = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            in_valid = 1'b1;
            in_data  = {2{8'(8'h50 + j)}};
            exp_q.push_back(in_data);
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b want=1", out_valid); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL areset_data got=%h want=0000", out_data); end
        total++; if (cur_tap !== 3'd4) begin bad++; $display("FAIL areset_tap got=%0d want=4", cur_tap); end
        exp_q.delete();
        en = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tap = 3'd4; en = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            in_valid = (j == 1);
            in_data  = 16'h7777;
            if (j == 1) exp_q.push_back(in_data);
            tick();
            total++;
            if (out_valid !== (j == 4)) begin
                bad++; $display("FAIL areset_restart_valid edge=%0d got=%b want=%b", j, out_valid, (j == 4));
            end else if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (out_data !== e) begin bad++; $display("FAIL areset_restart_data got=%h want=%h", out_data, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_retune();
        test_flush();
        test_clamp();
        test_async_reset();
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
